// File: rtl/string_assembler_pkg.sv
// Shared definitions for the byte-serial string assembler: character geometry,
// the NUL terminator, FSM state encoding and the lane-select decode.
package string_assembler_pkg;

  localparam int CHAR_W    = 8;
  localparam int MAX_CHARS = 8;
  localparam int STR_W     = CHAR_W * MAX_CHARS;
  localparam int FILL_W    = $clog2(MAX_CHARS + 1);

  localparam logic [CHAR_W-1:0] NUL      = '0;
  localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(MAX_CHARS - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // One-hot lane select from the current fill position.
  function automatic logic [MAX_CHARS-1:0] lane_onehot(input logic [FILL_W-1:0] idx);
    logic [MAX_CHARS-1:0] oh;
    oh = '0;
    for (int k = 0; k < MAX_CHARS; k++) begin
      oh[k] = (idx == FILL_W'(k));
    end
    return oh;
  endfunction

endpackage

// File: rtl/string_assembler_if.sv
// Character-in / string-out handshake bundle for the string assembler.
// master: the upstream/downstream environment; slave: the assembler itself.
interface string_assembler_if;
  import string_assembler_pkg::*;

  logic [CHAR_W-1:0] char_in;
  logic              char_valid;
  logic              char_ready;
  logic [STR_W-1:0]  string_out;
  logic              string_valid;
  logic              string_ready;
  logic [FILL_W-1:0] fill_count;
  logic              no_null;

  modport master (
    output char_in, char_valid, string_ready,
    input  char_ready, string_out, string_valid, fill_count, no_null
  );

  modport slave (
    input  char_in, char_valid, string_ready,
    output char_ready, string_out, string_valid, fill_count, no_null
  );

endinterface

// File: rtl/string_assembler.sv
// Packs one character per cycle into a 64-bit string (first char in the low byte),
// closing on NUL or on the 8th character, then holds the string until accepted.
// Unfilled lanes stay zero so a downstream length finder sees the right length.
module string_assembler
  import string_assembler_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  string_assembler_if.slave bus
);

  state_t               state_q;
  state_t               state_d;
  logic [STR_W-1:0]     string_q;
  logic [FILL_W-1:0]    fill_q;
  logic                 no_null_q;

  logic                 accept;
  logic                 is_nul;
  logic                 is_last;
  logic                 retire;
  logic [MAX_CHARS-1:0] lane_we;

  // Handshake qualifiers; char_ready depends on state only.
  assign accept  = (state_q == S_FILL) && bus.char_valid;
  assign is_nul  = (bus.char_in == NUL);
  assign is_last = (fill_q == LAST_IDX);
  assign retire  = (state_q == S_HOLD) && bus.string_ready;
  assign lane_we = lane_onehot(fill_q) & {MAX_CHARS{accept && !is_nul}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state: close on NUL or on the final lane, reopen when the string is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (accept && (is_nul || is_last)) state_d = S_HOLD;
      S_HOLD: if (bus.string_ready)              state_d = S_FILL;
      default:                                   state_d = S_FILL;
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    bus.char_ready   = (state_q == S_FILL);
    bus.string_valid = (state_q == S_HOLD);
  end

  // String lanes: write the addressed lane, clear everything when the string retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      string_q <= '0;
    end else if (retire) begin
      string_q <= '0;
    end else begin
      for (int k = 0; k < MAX_CHARS; k++) begin
        if (lane_we[k]) string_q[k*CHAR_W +: CHAR_W] <= bus.char_in;
      end
    end
  end

  // Fill count and no-NUL flag; a NUL terminator is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q    <= '0;
      no_null_q <= 1'b0;
    end else if (retire) begin
      fill_q    <= '0;
      no_null_q <= 1'b0;
    end else if (accept && !is_nul) begin
      fill_q    <= fill_q + FILL_W'(1);
      no_null_q <= is_last;
    end
  end

  assign bus.string_out = string_q;
  assign bus.fill_count = fill_q;
  assign bus.no_null    = no_null_q;

endmodule

// File: tb/tb_string_assembler.sv
// Directed bench for string_assembler: termination on NUL and on 8 chars, empty string,
// backpressure with a pending char, async reset mid-string, back-to-back strings.
module tb_string_assembler;
  import string_assembler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  string_assembler_if bus ();

  string_assembler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Number of bytes before the first NUL, as the downstream length finder reports it.
  function automatic int ref_len(input logic [63:0] s);
    int len;
    len = 8;
    for (int k = 7; k >= 0; k--) if (s[k*8 +: 8] == 8'h00) len = k;
    return len;
  endfunction

  // Present one char and hold it until it is accepted; reports refused cycles.
  task automatic send_char(input logic [7:0] c, output int waits);
    logic ok;
    ok    = 1'b0;
    waits = 0;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = bus.char_ready;
      @(posedge clk);
      if (!ok) waits++;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    #1;
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
  endtask

  task automatic send(input logic [7:0] c);
    int w;
    send_char(c, w);
  endtask

  // Accept the held string for one cycle.
  task automatic take_string();
    bus.string_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.string_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [63:0] held;
    bus.char_in      = 8'h00;
    bus.char_valid   = 1'b0;
    bus.string_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out",   bus.string_out,   64'd0);
    check("rst_fill",  bus.fill_count,   64'd0);
    check("rst_valid", bus.string_valid, 64'd0);
    check("rst_nonull",bus.no_null,      64'd0);
    check("rst_ready", bus.char_ready,   64'd1);
    @(posedge clk); #1;

    // 1: AA, BB, NUL
    send(8'hAA);
    check("t1_valid_early", bus.string_valid, 64'd0);
    check("t1_fill1",       bus.fill_count,   64'd1);
    send(8'hBB);
    send(8'h00);
    check("t1_out",    bus.string_out,   64'h000000000000BBAA);
    check("t1_fill",   bus.fill_count,   64'd2);
    check("t1_nonull", bus.no_null,      64'd0);
    check("t1_valid",  bus.string_valid, 64'd1);
    take_string();
    check("t1_clr_out",   bus.string_out,   64'd0);
    check("t1_clr_valid", bus.string_valid, 64'd0);

    // 2: eight chars, no NUL
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11));
    check("t2_out",    bus.string_out, 64'h8877665544332211);
    check("t2_fill",   bus.fill_count, 64'd8);
    check("t2_nonull", bus.no_null,    64'd1);
    check("t2_ready",  bus.char_ready, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t2_hold_out",   bus.string_out,   64'h8877665544332211);
    check("t2_hold_valid", bus.string_valid, 64'd1);
    take_string();
    check("t2_clr_nonull", bus.no_null,    64'd0);
    check("t2_clr_fill",   bus.fill_count, 64'd0);

    // 3: empty string
    send(8'h00);
    check("t3_out",   bus.string_out,   64'd0);
    check("t3_fill",  bus.fill_count,   64'd0);
    check("t3_valid", bus.string_valid, 64'd1);
    check("t3_len",   ref_len(bus.string_out), 64'd0);
    take_string();

    // 4: backpressure with a pending char
    send(8'hC1);
    send(8'h00);
    held = 64'h00000000000000C1;
    bus.char_in    = 8'hD1;
    bus.char_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_bp_out",   bus.string_out, held);
      check("t4_bp_ready", bus.char_ready, 64'd0);
      @(posedge clk); #1;
    end
    bus.string_ready = 1'b1;
    @(posedge clk); #1;
    bus.string_ready = 1'b0;
    check("t4_retire_valid", bus.string_valid, 64'd0);
    check("t4_retire_fill",  bus.fill_count,   64'd0);
    send_char(8'hD1, w);
    check("t4_waits", w, 64'd0);
    check("t4_lane0", bus.string_out, 64'h00000000000000D1);
    check("t4_fill",  bus.fill_count, 64'd1);
    send(8'h00);
    take_string();

    // 5: async reset after three chars
    send(8'h31);
    send(8'h32);
    send(8'h33);
    check("t5_pre_fill", bus.fill_count, 64'd3);
    #2 rst = 1'b1;
    #1;
    check("t5_out",    bus.string_out,   64'd0);
    check("t5_fill",   bus.fill_count,   64'd0);
    check("t5_valid",  bus.string_valid, 64'd0);
    check("t5_nonull", bus.no_null,      64'd0);
    @(posedge clk); #1 rst = 1'b0;
    send(8'h41);
    send(8'h00);
    check("t5_out2", bus.string_out, 64'h0000000000000041);
    take_string();

    // 6: back-to-back with string_ready tied high
    bus.string_ready = 1'b1;
    send(8'hA1);
    send(8'h00);
    check("t6_out_a",   bus.string_out,   64'h00000000000000A1);
    check("t6_valid_a", bus.string_valid, 64'd1);
    check("t6_len_a",   ref_len(bus.string_out), 64'd1);
    check("t6_bubble",  bus.char_ready,   64'd0);
    send_char(8'hB1, w);
    check("t6_waits", w, 64'd1);
    send(8'hB2);
    send(8'h00);
    check("t6_out_b",  bus.string_out, 64'h000000000000B2B1);
    check("t6_len_b",  ref_len(bus.string_out), 64'd2);
    check("t6_fill_b", bus.fill_count, 64'd2);
    @(posedge clk); #1;
    bus.string_ready = 1'b0;
    check("t6_idle_valid", bus.string_valid, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
